axi_slave_mem: RTL and testbench



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_addr_gen.sv | 44 ++++
 rtl/axi_slave_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_slave_mem.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings for the memory slave: burst types, response codes and FSM states.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational AXI beat-address stepper plus burst legality check; zero latency, no handshake.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [2:0]            i_size,
    input  logic [1:0]            i_burst,
    output logic [ADDR_WIDTH-1:0] o_next_addr,
    output logic                  o_err
);

    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] w_step;
    logic [ADDR_WIDTH-1:0] w_wrap_mask;
    logic [ADDR_WIDTH-1:0] w_incr;
    logic                  w_len_ok;

    always_comb begin
        w_step      = ADDR_WIDTH'(1) << i_size;
        // WRAP container is (LEN+1) transfers of 2^SIZE bytes, aligned to its own size
        w_wrap_mask = ((ADDR_WIDTH'(i_len) + ADDR_WIDTH'(1)) << i_size) - ADDR_WIDTH'(1);
        w_incr      = i_addr + w_step;
        w_len_ok    = (i_len == LEN_WIDTH'(1)) || (i_len == LEN_WIDTH'(3)) ||
                      (i_len == LEN_WIDTH'(7)) || (i_len == LEN_WIDTH'(15));

        case (burst_e'(i_burst))
            BURST_FIXED: o_next_addr = i_addr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     o_next_addr = w_incr;
        endcase

        o_err = (burst_e'(i_burst) == BURST_RSVD) ||
                (i_size > 3'(MAX_SIZE)) ||
                ((burst_e'(i_burst) == BURST_WRAP) &&
                 (!w_len_ok || ((i_addr & (w_step - ADDR_WIDTH'(1))) != '0)));
    end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory slave with independent write/read burst engines; RDATA registered one cycle after
// each AR/R handshake, BVALID one cycle after WLAST, all outputs held while the master stalls.
module axi_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [LEN_WIDTH-1:0]    AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [LEN_WIDTH-1:0]    ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    output logic                    RVALID,
    input  logic                    RREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> OFFS);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Holds both address channels off until the first edge after reset release
    logic r_live;

    w_state_e              r_wstate, w_wstate_nxt;
    logic [ID_WIDTH-1:0]   r_awid;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [LEN_WIDTH-1:0]  r_awlen, r_wbeat;
    logic [2:0]            r_awsize;
    logic [1:0]            r_awburst, r_bresp;
    logic                  r_werr, r_wover;
    logic [ADDR_WIDTH-1:0] w_wag_next;
    logic                  w_wag_err, w_aw_hs, w_w_hs;

    r_state_e              r_rstate, w_rstate_nxt;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [LEN_WIDTH-1:0]  r_arlen, r_rbeat;
    logic [2:0]            r_arsize;
    logic [1:0]            r_arburst;
    logic                  r_rerr;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ADDR_WIDTH-1:0] w_rag_next;
    logic                  w_rag_err, w_ar_hs, w_r_hs;

    assign w_aw_hs = AWVALID & AWREADY;
    assign w_w_hs  = WVALID & WREADY;
    assign w_ar_hs = ARVALID & ARREADY;
    assign w_r_hs  = RVALID & RREADY;

    // Idle: check the incoming request; busy: step the latched beat address
    axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wag (
        .i_addr      ((r_wstate == W_IDLE) ? AWADDR  : r_awaddr),
        .i_len       ((r_wstate == W_IDLE) ? AWLEN   : r_awlen),
        .i_size      ((r_wstate == W_IDLE) ? AWSIZE  : r_awsize),
        .i_burst     ((r_wstate == W_IDLE) ? AWBURST : r_awburst),
        .o_next_addr (w_wag_next),
        .o_err       (w_wag_err)
    );

    axi_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rag (
        .i_addr      ((r_rstate == R_IDLE) ? ARADDR  : r_araddr),
        .i_len       ((r_rstate == R_IDLE) ? ARLEN   : r_arlen),
        .i_size      ((r_rstate == R_IDLE) ? ARSIZE  : r_arsize),
        .i_burst     ((r_rstate == R_IDLE) ? ARBURST : r_arburst),
        .o_next_addr (w_rag_next),
        .o_err       (w_rag_err)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_live   <= 1'b0;
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        AWREADY      = 1'b0;
        WREADY       = 1'b0;
        BVALID       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                AWREADY = r_live;
                if (AWVALID && r_live) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && WLAST) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        ARREADY      = 1'b0;
        RVALID       = 1'b0;
        RLAST        = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                ARREADY = r_live;
                if (ARVALID && r_live) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                RLAST  = (r_rbeat == r_arlen);
                if (RREADY && RLAST) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_werr    <= 1'b0;
            r_wover   <= 1'b0;
            r_wbeat   <= '0;
            r_bresp   <= '0;
        end else if (w_aw_hs) begin
            r_awid    <= AWID;
            r_awaddr  <= AWADDR;
            r_awlen   <= AWLEN;
            r_awsize  <= AWSIZE;
            r_awburst <= AWBURST;
            r_werr    <= w_wag_err;
            r_wover   <= 1'b0;
            r_wbeat   <= '0;
        end else if (w_w_hs) begin
            r_awaddr <= w_wag_next;
            r_wbeat  <= r_wbeat + LEN_WIDTH'(1);
            // Burst ran past AWLEN without WLAST: remembered so the response reports it
            if ((r_wbeat == r_awlen) && !WLAST) r_wover <= 1'b1;
            if (WLAST)
                r_bresp <= (r_werr || r_wover || (r_wbeat != r_awlen)) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_w_hs && !r_werr) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) r_mem[f_idx(r_awaddr)][b*8 +: 8] <= WDATA[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rid     <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rerr    <= 1'b0;
            r_rbeat   <= '0;
            r_rdata   <= '0;
        end else if (w_ar_hs) begin
            r_rid     <= ARID;
            r_araddr  <= ARADDR;
            r_arlen   <= ARLEN;
            r_arsize  <= ARSIZE;
            r_arburst <= ARBURST;
            r_rerr    <= w_rag_err;
            r_rbeat   <= '0;
            r_rdata   <= w_rag_err ? '0 : r_mem[f_idx(ARADDR)];
        end else if (w_r_hs) begin
            r_araddr <= w_rag_next;
            r_rbeat  <= r_rbeat + LEN_WIDTH'(1);
            if (!RLAST) r_rdata <= r_rerr ? '0 : r_mem[f_idx(w_rag_next)];
        end
    end

    assign BID   = r_awid;
    assign BRESP = r_bresp;
    assign RID   = r_rid;
    assign RDATA = r_rdata;
    assign RRESP = r_rerr ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scenario bench for axi_slave_mem: expected beats queued at stimulus time, compared as the DUT returns them.
module tb_axi_slave_mem;

    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic [3:0]  AWID, BID, ARID, RID, WSTRB;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic [31:0] WDATA, RDATA;
    logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;

    always #5 ACLK = ~ACLK;

    axi_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .RVALID(RVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    int          vectors = 0;
    int          miscompares = 0;
    beat_t       exp_q[$];
    beat_t       got_q[$];
    logic [31:0] wq_data[$];
    logic [3:0]  wq_strb[$];

    function automatic beat_t mk(input logic [31:0] d, input logic l, input logic [1:0] r);
        beat_t b;
        b.data = d; b.last = l; b.resp = r;
        return b;
    endfunction

    // Drives one write burst from wq_data/wq_strb (WLAST on the final queued beat).
    task automatic do_write(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bdelay,
                            output logic [1:0] bresp, output logic [3:0] bid, output int blat,
                            output bit awok, output bit stable, output bit to);
        int n;
        bresp = '0; bid = '0; blat = -1; awok = 0; stable = 1; to = 0;
        AWVALID = 1; AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        n = 0;
        while (!AWREADY) begin
            if (n++ >= 50) begin to = 1; AWVALID = 0; return; end
            @(posedge ACLK); #1;
        end
        @(posedge ACLK); #1;
        AWVALID = 0;
        awok = !AWREADY && WREADY;
        for (int i = 0; i < wq_data.size(); i++) begin
            WVALID = 1; WDATA = wq_data[i]; WSTRB = wq_strb[i]; WLAST = (i == wq_data.size() - 1);
            n = 0;
            while (!WREADY) begin
                if (n++ >= 50) begin to = 1; WVALID = 0; WLAST = 0; return; end
                @(posedge ACLK); #1;
            end
            @(posedge ACLK); #1;
        end
        WVALID = 0; WLAST = 0;
        wq_data.delete(); wq_strb.delete();
        blat = 0;
        while (!BVALID) begin
            if (blat >= 50) begin to = 1; return; end
            @(posedge ACLK); #1; blat++;
        end
        bresp = BRESP; bid = BID;
        repeat (bdelay) begin
            @(posedge ACLK); #1;
            if (!BVALID || BRESP !== bresp || BID !== bid) stable = 0;
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        BREADY = 0;
        if (BVALID) stable = 0;
    endtask

    // Issues one read burst and collects accepted beats into got_q, RREADY following rr_pat cyclically.
    task automatic do_read(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [3:0] rr_pat,
                           output int lat, output int cycles, output bit stable, output bit to,
                           output logic [3:0] rid, output bit trail);
        int    n, k;
        bit    holding, done;
        beat_t held, b;
        got_q.delete();
        lat = 0; cycles = 0; stable = 1; to = 0; rid = '0; trail = 0; k = 0; holding = 0; done = 0;
        held = '0;
        ARVALID = 1; ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        n = 0;
        while (!ARREADY) begin
            if (n++ >= 50) begin to = 1; ARVALID = 0; return; end
            @(posedge ACLK); #1;
        end
        @(posedge ACLK); #1;
        ARVALID = 0;
        while (!RVALID) begin
            if (lat >= 50) begin to = 1; return; end
            @(posedge ACLK); #1; lat++;
        end
        while (!done) begin
            RREADY = rr_pat[k % 4]; k++;
            if (holding && (RVALID !== 1'b1 || RDATA !== held.data || RLAST !== held.last ||
                            RRESP !== held.resp)) stable = 0;
            holding = 0;
            if (RVALID && RREADY) begin
                b = mk(RDATA, RLAST, RRESP);
                got_q.push_back(b);
                if (got_q.size() == 1) rid = RID;
                if (RLAST || got_q.size() >= int'(len) + 1) done = 1;
            end else if (RVALID) begin
                held = mk(RDATA, RLAST, RRESP);
                holding = 1;
            end
            cycles++;
            @(posedge ACLK); #1;
            if (cycles > 200) begin to = 1; done = 1; end
        end
        RREADY = 0;
        trail = RVALID;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        vectors++;
        if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: aw/w/b/ar/r/rlast=%b, expected 000000",
                     {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
        end
        vectors++;
        if ({BID, BRESP, RID, RDATA, RRESP} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: bid=%h bresp=%h rid=%h rdata=%h rresp=%h, expected all 0",
                     BID, BRESP, RID, RDATA, RRESP);
        end
        @(negedge ACLK);
        ARESET = 0;
        #1;
        vectors++;
        if (AWREADY !== 1'b0 || ARREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_early: awready=%b arready=%b, expected 0 0", AWREADY, ARREADY);
        end
        @(posedge ACLK); #1;
        vectors++;
        if (AWREADY !== 1'b1 || ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: awready=%b arready=%b, expected 1 1", AWREADY, ARREADY);
        end
    endtask

    task automatic test_incr();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc; bit awok, st, to, trail;
        beat_t e, g;
        for (int i = 0; i < 4; i++) begin wq_data.push_back(32'hA0 + 32'(i)); wq_strb.push_back(4'hF); end
        do_write(4'h5, 16'h0010, 8'd3, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || !awok || bresp !== OKAY || bid !== 4'h5 || blat != 0) begin
            miscompares++;
            $display("FAIL incr_write: to=%0b awok=%0b bresp=%h bid=%h blat=%0d, expected 0 1 0 5 0",
                     to, awok, bresp, bid, blat);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'hA0 + 32'(i), i == 3, OKAY));
        do_read(4'h6, 16'h0010, 8'd3, 3'd2, INCR, 4'hF, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || lat != 0 || cyc != 4 || rid !== 4'h6 || trail) begin
            miscompares++;
            $display("FAIL incr_read_timing: to=%0b lat=%0d cycles=%0d rid=%h trail=%0b, expected 0 0 4 6 0",
                     to, lat, cyc, rid, trail);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL incr_beats: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL incr_beat: got %h/%b/%h, expected %h/%b/%h", g.data, g.last, g.resp, e.data, e.last, e.resp);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_wrap();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc; bit awok, st, to, trail;
        beat_t e, g;
        for (int i = 1; i <= 4; i++) begin wq_data.push_back(32'(i)); wq_strb.push_back(4'hF); end
        do_write(4'h1, 16'h0010, 8'd3, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        exp_q.push_back(mk(32'd3, 1'b0, OKAY));
        exp_q.push_back(mk(32'd4, 1'b0, OKAY));
        exp_q.push_back(mk(32'd1, 1'b0, OKAY));
        exp_q.push_back(mk(32'd2, 1'b1, OKAY));
        do_read(4'h2, 16'h0018, 8'd3, 3'd2, WRAP, 4'hF, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL wrap_beats: to=%0b got %0d beats, expected 0 and %0d", to, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL wrap_beat: got %h/%b/%h, expected %h/%b/%h", g.data, g.last, g.resp, e.data, e.last, e.resp);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_strobe_fixed();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc; bit awok, st, to, trail;
        beat_t e, g;
        wq_data = '{32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333};
        wq_strb = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(4'h3, 16'h0020, 8'd3, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        wq_data.push_back(32'hFFFFFFFF); wq_strb.push_back(4'h3);
        do_write(4'h3, 16'h0020, 8'd0, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        wq_data = '{32'd1, 32'd2, 32'd3};
        wq_strb = '{4'hF, 4'hF, 4'hF};
        do_write(4'h4, 16'h0024, 8'd2, 3'd2, FIXED, 0, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || bresp !== OKAY || bid !== 4'h4) begin
            miscompares++;
            $display("FAIL fixed_bresp: to=%0b bresp=%h bid=%h, expected 0 0 4", to, bresp, bid);
        end
        exp_q.push_back(mk(32'h1234FFFF, 1'b0, OKAY));
        exp_q.push_back(mk(32'd3, 1'b0, OKAY));
        exp_q.push_back(mk(32'h22222222, 1'b0, OKAY));
        exp_q.push_back(mk(32'h33333333, 1'b1, OKAY));
        do_read(4'h7, 16'h0020, 8'd3, 3'd2, INCR, 4'hF, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL strobe_beats: to=%0b got %0d beats, expected 0 and %0d", to, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL strobe_beat: got %h/%b/%h, expected %h/%b/%h", g.data, g.last, g.resp, e.data, e.last, e.resp);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_slverr();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc; bit awok, st, to, trail;
        beat_t e, g;
        wq_data.push_back(32'hCAFEF00D); wq_strb.push_back(4'hF);
        do_write(4'h0, 16'h0030, 8'd0, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        wq_data = '{32'hBAD0BAD0, 32'hBAD1BAD1};
        wq_strb = '{4'hF, 4'hF};
        do_write(4'h9, 16'h0030, 8'd1, 3'd2, RSVD, 0, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || bresp !== SLVERR || bid !== 4'h9) begin
            miscompares++;
            $display("FAIL rsvd_bresp: to=%0b bresp=%h bid=%h, expected 0 2 9", to, bresp, bid);
        end
        wq_data.push_back(32'h5); wq_strb.push_back(4'hF);
        do_write(4'hA, 16'h0034, 8'd1, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || bresp !== SLVERR) begin
            miscompares++;
            $display("FAIL early_wlast: to=%0b bresp=%h, expected 0 2", to, bresp);
        end
        wq_data = '{32'h6, 32'h7};
        wq_strb = '{4'hF, 4'hF};
        do_write(4'hB, 16'h0034, 8'd0, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || bresp !== SLVERR) begin
            miscompares++;
            $display("FAIL late_wlast: to=%0b bresp=%h, expected 0 2", to, bresp);
        end
        exp_q.push_back(mk(32'hCAFEF00D, 1'b1, OKAY));
        exp_q.push_back(mk(32'h0, 1'b0, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b1, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b0, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b0, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b1, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b0, SLVERR));
        exp_q.push_back(mk(32'h0, 1'b1, SLVERR));
        do_read(4'h1, 16'h0030, 8'd0, 3'd2, INCR, 4'hF, lat, cyc, st, to, rid, trail);
        for (int i = 0; i < 3; i++) begin
            beat_t keep[$];
            keep = got_q;
            if (i == 0) do_read(4'h2, 16'h0030, 8'd1, 3'd3, INCR, 4'hF, lat, cyc, st, to, rid, trail);
            if (i == 1) do_read(4'h3, 16'h0030, 8'd2, 3'd2, WRAP, 4'hF, lat, cyc, st, to, rid, trail);
            if (i == 2) do_read(4'h4, 16'h0032, 8'd1, 3'd2, WRAP, 4'hF, lat, cyc, st, to, rid, trail);
            got_q = {keep, got_q};
        end
        vectors++;
        if (to || got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL slverr_beats: to=%0b got %0d beats, expected 0 and %0d", to, got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL slverr_beat: got %h/%b/%h, expected %h/%b/%h", g.data, g.last, g.resp, e.data, e.last, e.resp);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc; bit awok, st, to, trail;
        beat_t e, g;
        for (int i = 0; i < 4; i++) begin wq_data.push_back(32'h4000 + 32'(i)); wq_strb.push_back(4'hF); end
        do_write(4'hC, 16'h0040, 8'd3, 3'd2, INCR, 5, bresp, bid, blat, awok, st, to);
        vectors++;
        if (to || !st || bresp !== OKAY || bid !== 4'hC) begin
            miscompares++;
            $display("FAIL bready_hold: to=%0b stable=%0b bresp=%h bid=%h, expected 0 1 0 c", to, st, bresp, bid);
        end
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h4000 + 32'(i), i == 3, OKAY));
        do_read(4'hD, 16'h0040, 8'd3, 3'd2, INCR, 4'b1001, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || !st || trail || rid !== 4'hD) begin
            miscompares++;
            $display("FAIL rready_hold: to=%0b stable=%0b trail=%0b rid=%h, expected 0 1 0 d", to, st, trail, rid);
        end
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL bp_beats: got %0d beats, expected %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL bp_beat: got %h/%b/%h, expected %h/%b/%h", g.data, g.last, g.resp, e.data, e.last, e.resp);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_same_cycle();
        logic [1:0] bresp; logic [3:0] bid, rid; int blat, lat, cyc, n; bit awok, st, to, trail;
        wq_data.push_back(32'h0BADC0DE); wq_strb.push_back(4'hF);
        do_write(4'h1, 16'h0050, 8'd0, 3'd2, INCR, 0, bresp, bid, blat, awok, st, to);
        AWVALID = 1; AWID = 4'h1; AWADDR = 16'h0050; AWLEN = 0; AWSIZE = 3'd2; AWBURST = INCR;
        n = 0;
        while (!AWREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        AWVALID = 0;
        WVALID = 1; WDATA = 32'h600DF00D; WSTRB = 4'hF; WLAST = 1;
        ARVALID = 1; ARID = 4'h2; ARADDR = 16'h0050; ARLEN = 0; ARSIZE = 3'd2; ARBURST = INCR;
        vectors++;
        if (WREADY !== 1'b1 || ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_ready: wready=%b arready=%b, expected 1 1", WREADY, ARREADY);
        end
        @(posedge ACLK); #1;
        WVALID = 0; WLAST = 0; ARVALID = 0;
        vectors++;
        if (RVALID !== 1'b1 || RDATA !== 32'h0BADC0DE) begin
            miscompares++;
            $display("FAIL same_cycle_old: rvalid=%b rdata=%h, expected 1 0badc0de", RVALID, RDATA);
        end
        RREADY = 1; BREADY = 1;
        @(posedge ACLK); #1;
        RREADY = 0; BREADY = 0;
        exp_q.push_back(mk(32'h600DF00D, 1'b1, OKAY));
        do_read(4'h3, 16'h0050, 8'd0, 3'd2, INCR, 4'hF, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL same_cycle_new: to=%0b beats=%0d data=%h, expected 0 1 600df00d",
                     to, got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hX);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_midburst();
        logic [3:0] rid; int lat, cyc, n; bit st, to, trail;
        bit seen;
        ARVALID = 1; ARID = 4'h5; ARADDR = 16'h0040; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = INCR;
        n = 0;
        while (!ARREADY && n < 50) begin @(posedge ACLK); #1; n++; end
        @(posedge ACLK); #1;
        ARVALID = 0; RREADY = 1;
        @(posedge ACLK); #1;
        vectors++;
        if (RVALID !== 1'b1 || RDATA !== 32'h4001 || RLAST !== 1'b0) begin
            miscompares++;
            $display("FAIL midburst_beat2: rvalid=%b rdata=%h rlast=%b, expected 1 00004001 0", RVALID, RDATA, RLAST);
        end
        ARESET = 1;
        #1;
        vectors++;
        if (RVALID !== 1'b0 || RLAST !== 1'b0 || ARREADY !== 1'b0 || BVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL midburst_in_reset: rvalid=%b rlast=%b arready=%b bvalid=%b, expected 0 0 0 0",
                     RVALID, RLAST, ARREADY, BVALID);
        end
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 0;
        @(posedge ACLK); #1;
        vectors++;
        if (ARREADY !== 1'b1 || RVALID !== 1'b0 || RLAST !== 1'b0) begin
            miscompares++;
            $display("FAIL midburst_release: arready=%b rvalid=%b rlast=%b, expected 1 0 0", ARREADY, RVALID, RLAST);
        end
        seen = 0;
        repeat (4) begin
            @(posedge ACLK); #1;
            if (RVALID || RLAST || BVALID) seen = 1;
        end
        RREADY = 0;
        vectors++;
        if (seen) begin
            miscompares++;
            $display("FAIL midburst_residual: residual R/B activity=%0b, expected 0", seen);
        end
        exp_q.push_back(mk(32'h4002, 1'b1, OKAY));
        do_read(4'h6, 16'h0048, 8'd0, 3'd2, INCR, 4'hF, lat, cyc, st, to, rid, trail);
        vectors++;
        if (to || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miscompares++;
            $display("FAIL midburst_recover: to=%0b beats=%0d data=%h, expected 0 1 00004002",
                     to, got_q.size(), (got_q.size() > 0) ? got_q[0].data : 32'hX);
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        ARESET = 1;
        AWVALID = 0; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        WVALID = 0; WDATA = '0; WSTRB = '0; WLAST = 0; BREADY = 0;
        ARVALID = 0; ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; RREADY = 0;
        test_reset();
        test_incr();
        test_wrap();
        test_strobe_fixed();
        test_slverr();
        test_backpressure();
        test_same_cycle();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
